// File: rtl/hft_pkg.sv
// rtl/hft_pkg.sv - shared order-book types: book entry, message type and decoded message
// Ports: none (package). Used by order_fifo, order_dispatcher and order_book.
package hft_pkg;

    typedef struct packed {
        logic [15:0] price;
        logic [15:0] order_id;
        logic [15:0] quantity;
    } book_entry;

    typedef enum logic [1:0] {
        MSG_ADD    = 2'd0,
        MSG_CANCEL = 2'd1,
        MSG_DELETE = 2'd2,
        MSG_RSVD   = 2'd3
    } msg_type_e;

    typedef struct packed {
        msg_type_e   msg_type;
        logic [15:0] price;
        logic [15:0] order_id;
        logic [15:0] quantity;
    } order_msg;

endpackage

// File: rtl/order_fifo.sv
// rtl/order_fifo.sv - synchronous FIFO of order_msg with occupancy, full and empty
// Ports: clk, rst (async active-low), push/push_data, pop/pop_data (head, valid when !empty),
//        count (occupancy), full, empty. Push while full and pop while empty are ignored.
module order_fifo
    import hft_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  order_msg               push_data,
    input  logic                   pop,
    output order_msg               pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    order_msg        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/order_dispatcher.sv
// rtl/order_dispatcher.sv - buffers decoded add/cancel/delete messages and issues them to order_book
// Ports: clk, rst (async active-low); in_valid/in_ready/in_type/in_price/in_order_id/in_quantity
//        message input; book_busy from order_book; start_book issue pulse with held fields
//        incoming_order, request_type, delete_flag, cancel_order_id, cancel_quantity;
//        status fifo_count, drop_count, idle; add_count/cancel_count/delete_count statistics.
// Build option: DISPATCH_STATS_EN builds the saturating issue counters; otherwise they read 0.
module order_dispatcher
    import hft_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_type,
    input  logic [15:0]            in_price,
    input  logic [15:0]            in_order_id,
    input  logic [15:0]            in_quantity,
    input  logic                   book_busy,
    output book_entry              incoming_order,
    output logic                   start_book,
    output logic                   request_type,
    output logic                   delete_flag,
    output logic [15:0]            cancel_order_id,
    output logic [15:0]            cancel_quantity,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             drop_count,
    output logic                   idle,
    output logic [15:0]            add_count,
    output logic [15:0]            cancel_count,
    output logic [15:0]            delete_count
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_WAIT_DONE} state_e;

    localparam int            TW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    state_e   state, state_nxt;
    logic [TW-1:0] ack_timer;
    logic     issue;
    logic     full, empty;
    logic     accept, push;
    order_msg head;
    order_msg push_data;

    // in_ready comes only from the registered occupancy, never from a same-cycle pop.
    assign in_ready  = rst & ~full;
    assign accept    = in_valid & in_ready;
    assign push      = accept & (in_type != MSG_RSVD);
    assign push_data = {in_type, in_price, in_order_id, in_quantity};
    assign idle      = (state == S_IDLE) & empty;

    order_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (issue),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ack_timer <= '0;
        end else begin
            state     <= state_nxt;
            ack_timer <= (state == S_WAIT_ACK) ? ack_timer + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !book_busy) begin
                    issue     = 1'b1;
                    state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // A book that never raises busy is treated as having finished instantly.
                if (book_busy)                   state_nxt = S_WAIT_DONE;
                else if (ack_timer == TMO_LAST)  state_nxt = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (!book_busy) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Field outputs only change on an issue edge, so they stay put for the whole book operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_book      <= 1'b0;
            incoming_order  <= '0;
            request_type    <= 1'b0;
            delete_flag     <= 1'b0;
            cancel_order_id <= '0;
            cancel_quantity <= '0;
        end else begin
            start_book <= issue;
            if (issue) begin
                incoming_order  <= '0;
                request_type    <= 1'b1;
                delete_flag     <= 1'b0;
                cancel_order_id <= head.order_id;
                cancel_quantity <= '0;
                case (head.msg_type)
                    MSG_ADD: begin
                        incoming_order  <= '{price: head.price, order_id: head.order_id,
                                             quantity: head.quantity};
                        request_type    <= 1'b0;
                        cancel_order_id <= '0;
                    end
                    MSG_CANCEL: cancel_quantity <= head.quantity;
                    MSG_DELETE: delete_flag     <= 1'b1;
                    default:    cancel_order_id <= '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                                   drop_count <= '0;
        else if (accept && in_type == MSG_RSVD && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end

`ifdef DISPATCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_count    <= '0;
            cancel_count <= '0;
            delete_count <= '0;
        end else if (issue) begin
            if (head.msg_type == MSG_ADD    && add_count    != 16'hFFFF) add_count    <= add_count + 1'b1;
            if (head.msg_type == MSG_CANCEL && cancel_count != 16'hFFFF) cancel_count <= cancel_count + 1'b1;
            if (head.msg_type == MSG_DELETE && delete_count != 16'hFFFF) delete_count <= delete_count + 1'b1;
        end
    end
`else
    assign add_count    = '0;
    assign cancel_count = '0;
    assign delete_count = '0;
`endif

endmodule

// File: tb/tb_order_dispatcher.sv
// tb/tb_order_dispatcher.sv - scoreboard bench for order_dispatcher with a busy-pulsing book model
module tb_order_dispatcher;
    import hft_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_type = '0;
    logic [15:0] in_price = '0, in_order_id = '0, in_quantity = '0;
    logic        book_busy;
    logic        busy_force = 1'b0, model_busy = 1'b0, ack_en = 1'b1;
    book_entry   incoming_order;
    logic        start_book, request_type, delete_flag;
    logic [15:0] cancel_order_id, cancel_quantity;
    logic [3:0]  fifo_count;
    logic [7:0]  drop_count;
    logic        idle;
    logic [15:0] add_count, cancel_count, delete_count;

    assign book_busy = busy_force | model_busy;

    order_dispatcher #(.DEPTH(DEPTH), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_price(in_price), .in_order_id(in_order_id), .in_quantity(in_quantity),
        .book_busy(book_busy), .incoming_order(incoming_order), .start_book(start_book),
        .request_type(request_type), .delete_flag(delete_flag),
        .cancel_order_id(cancel_order_id), .cancel_quantity(cancel_quantity),
        .fifo_count(fifo_count), .drop_count(drop_count), .idle(idle),
        .add_count(add_count), .cancel_count(cancel_count), .delete_count(delete_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  t;
        logic [47:0] order;
        logic        rt;
        logic        df;
        logic [15:0] cid;
        logic [15:0] cq;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur = '{default: 0};
    int   starts[$];
    int   last_start = -100;
    int   exp_add = 0, exp_can = 0, exp_del = 0, exp_drop = 0;

    // What the book must see for a message, straight from the type rules.
    function automatic exp_t model(logic [1:0] t, logic [15:0] p, logic [15:0] id, logic [15:0] q);
        exp_t e;
        e.t = t; e.order = '0; e.rt = (t != 2'd0); e.df = (t == 2'd2); e.cid = '0; e.cq = '0;
        if (t == 2'd0) e.order = {p, id, q};
        else begin
            e.cid = id;
            e.cq  = (t == 2'd1) ? q : 16'd0;
        end
        return e;
    endfunction

    task automatic chk(string name, logic [95:0] got, logic [95:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every issue pulse and checks held fields on all other cycles.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            cur = '{default: 0};
            last_start = -100;
            exp_add = 0; exp_can = 0; exp_del = 0;
        end else if (start_book) begin
            if (exp_q.size() == 0) chk("unexpected_start", 96'(1), 96'(0));
            else begin
                cur = exp_q.pop_front();
                chk("issue_fields",
                    96'({incoming_order, request_type, delete_flag, cancel_order_id, cancel_quantity}),
                    96'({cur.order, cur.rt, cur.df, cur.cid, cur.cq}));
                chk("spacing", 96'(cyc - last_start >= 3), 96'(1));
                starts.push_back(cyc);
                last_start = cyc;
                if (cur.t == 2'd0) exp_add++;
                if (cur.t == 2'd1) exp_can++;
                if (cur.t == 2'd2) exp_del++;
`ifdef DISPATCH_STATS_EN
                chk("stats", 96'({add_count, cancel_count, delete_count}),
                    96'({16'(exp_add), 16'(exp_can), 16'(exp_del)}));
`else
                chk("stats", 96'({add_count, cancel_count, delete_count}), 96'(0));
`endif
            end
        end else begin
            chk("held_fields",
                96'({incoming_order, request_type, delete_flag, cancel_order_id, cancel_quantity}),
                96'({cur.order, cur.rt, cur.df, cur.cid, cur.cq}));
        end
    end

    // Book model: busy rises one cycle after start_book and stays high for three cycles.
    initial forever begin
        @(posedge clk); #1;
        if (rst && start_book && ack_en) begin
            @(posedge clk); #1;
            model_busy = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            model_busy = 1'b0;
        end
    end

    task automatic send(logic [1:0] t, logic [15:0] p, logic [15:0] id, logic [15:0] q, output int acc);
        int budget = 200;
        in_type = t; in_price = p; in_order_id = id; in_quantity = q; in_valid = 1'b1;
        while (!in_ready && budget > 0) begin
            step();
            budget--;
        end
        acc = -1;
        if (!in_ready) begin
            chk("accept_timeout", 96'(0), 96'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (t != 2'd3) exp_q.push_back(model(t, p, id, q));
        else           exp_drop++;
        #1;
        in_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_drain(int budget = 400);
        while (!(idle && exp_q.size() == 0 && !book_busy) && budget > 0) begin
            step();
            budget--;
        end
        chk("drain", 96'(idle && exp_q.size() == 0), 96'(1));
    endtask

    task automatic wait_starts(int n, int budget = 100);
        while (starts.size() < n && budget > 0) begin
            step();
            budget--;
        end
        chk("start_seen", 96'(starts.size() >= n), 96'(1));
    endtask

    initial begin
        int acc, n;
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, n;
        step(2);
        chk("reset_state", 96'({fifo_count, start_book, idle, drop_count}), 96'({4'd0, 1'b0, 1'b1, 8'd0}));
        rst = 1'b1;
        step();
        chk("post_reset", 96'({in_ready, idle, incoming_order}), 96'({1'b1, 1'b1, 48'd0}));

        // single ADD: pulse one cycle after accept
        send(2'd0, 16'h0064, 16'd7, 16'd10, acc);
        wait_starts(1);
        chk("add_latency", 96'(starts[0]), 96'(acc + 1));
        wait_drain();
        chk("add_held", 96'({incoming_order, request_type, delete_flag}),
            96'({16'h0064, 16'd7, 16'd10, 1'b0, 1'b0}));

        // CANCEL then DELETE
        send(2'd1, 16'h1111, 16'd7, 16'd4, acc);
        send(2'd2, 16'h2222, 16'd9, 16'd55, acc);
        wait_drain();
        chk("delete_held", 96'({request_type, delete_flag, cancel_order_id, cancel_quantity}),
            96'({1'b1, 1'b1, 16'd9, 16'd0}));
`ifdef DISPATCH_STATS_EN
        chk("stats_t2", 96'({add_count, cancel_count, delete_count}), 96'({16'd1, 16'd1, 16'd1}));
`endif

        // FIFO full with book busy, then drain in order
        n = starts.size();
        busy_force = 1'b1;
        for (int i = 0; i < 8; i++) send(2'd0, 16'(i), 16'(100 + i), 16'(i + 1), acc);
        step();
        chk("full_state", 96'({fifo_count, in_ready}), 96'({4'd8, 1'b0}));
        in_type = 2'd0; in_price = 16'd8; in_order_id = 16'd108; in_quantity = 16'd9; in_valid = 1'b1;
        step(3);
        chk("ninth_stalls", 96'({fifo_count, in_ready}), 96'({4'd8, 1'b0}));
        busy_force = 1'b0;
        send(2'd0, 16'd8, 16'd108, 16'd9, acc);
        wait_drain();
        chk("drain_count", 96'(starts.size() - n), 96'(9));

        // reserved type is dropped
        n = starts.size();
        send(2'd3, 16'hBEEF, 16'd5, 16'd5, acc);
        step(6);
        chk("drop", 96'({drop_count, fifo_count, 8'(starts.size() - n)}), 96'({8'd1, 4'd0, 8'd0}));

        // ack timeout: no busy at all, next message issues 5 cycles after the first
        ack_en = 1'b0;
        send(2'd0, 16'd1, 16'd21, 16'd3, acc);
        send(2'd1, 16'd0, 16'd21, 16'd2, acc);
        wait_drain();
        chk("timeout_gap", 96'(starts[starts.size()-1] - starts[starts.size()-2]), 96'(5));
        ack_en = 1'b1;

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            ack_en = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 3));
            send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom), acc);
        end
        wait_drain(2000);
        ack_en = 1'b1;
        chk("drop_random", 96'(drop_count), 96'(8'(exp_drop)));

        // reset in the middle of a book operation with three queued
        n = starts.size();
        send(2'd0, 16'd1, 16'd2, 16'd3, acc);
        wait_starts(n + 1);
        busy_force = 1'b1;
        step(3);
        for (int i = 0; i < 3; i++) send(2'd1, 16'd0, 16'(40 + i), 16'd1, acc);
        step();
        chk("queued3", 96'(fifo_count), 96'(3));
        #2 rst = 1'b0;
        #1;
        chk("async_reset", 96'({fifo_count, start_book, incoming_order, request_type, delete_flag,
                                cancel_order_id, cancel_quantity}), 96'(0));
        step(2);
        busy_force = 1'b0;
        exp_drop = 0;
        rst = 1'b1;
        step();
        chk("after_reset", 96'({idle, in_ready, drop_count}), 96'({1'b1, 1'b1, 8'd0}));
        n = starts.size();
        step(12);
        chk("no_pulse_after_reset", 96'(starts.size() - n), 96'(0));
        send(2'd2, 16'd0, 16'd77, 16'd0, acc);
        wait_drain();
        chk("recover_issue", 96'(starts.size() - n), 96'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
